fsk_dec_scheduler: RTL and testbench
====================================

# fsk_dec_scheduler

Time-multiplexes a single shared 12-bit binary-to-4-digit-BCD converter across the five display quantities of the FSK receiver: amplitude, offset, F1 peak, F2 peak and the minimum-amplitude threshold. The scheduler replaces the per-value converter instances in the receiver top level. On each refresh request it snapshots all five binary values, converts them one at a time through the converter handshake, and holds the five BCD results stable for the indicator driver.

## Interface
- N_CH, 5, number of channels; fixed order 0 AMP, 1 SH, 2 AF1, 3 AF2, 4 AMIN
- W_BIN, 12, binary input width
- W_DEC, 16, BCD result width (4 nibbles)
- TO_CYC, 64, maximum cycles in WAIT before the timeout path is taken
- clk  in  1  system clock; all logic is rising-edge
- rst_n  in  1  asynchronous active-low reset
- st  in  1  refresh request; one-cycle pulse expected, level tolerated
- bin_amp, bin_sh, bin_af1, bin_af2, bin_amin  in  12 each  binary sources; the offset source is truncated to its low 12 bits upstream
- cv_st  out  1  converter start pulse
- cv_bin  out  12  converter operand
- cv_dec  in  16  converter BCD result
- cv_done  in  1  converter result valid
- dec_amp, dec_sh, dec_af1, dec_af2, dec_amin  out  16 each  BCD results
- busy  out  1  high from capture to end of DONE
- frame_done  out  1  one-cycle pulse after all five results are written
- err_to  out  1  sticky: a timeout occurred in the current or last frame

## Operation
- States: IDLE, ISSUE, WAIT, DONE; ch counter 0..N_CH-1.
- IDLE:
  - st=1 sampled: all five bin_* are captured into shadow registers, ch<=0, err_to<=0, go to ISSUE.
- ISSUE:
  - cv_st=1 and cv_bin=shadow[ch] for exactly this cycle.
  - Go to WAIT; to-counter<=0.
- WAIT:
  - cv_st=0; cv_bin holds shadow[ch].
  - cv_done=1 sampled: dec[ch]<=cv_dec.
  - Timeout, when to-counter reaches TO_CYC-1 without cv_done: dec[ch]<=16'hFFFF and err_to<=1.
  - Either event: ch==N_CH-1 goes to DONE; otherwise ch++ and go to ISSUE.
- DONE:
  - frame_done=1 for one cycle.
  - If pend=1: pend<=0, re-capture shadows, ch<=0, err_to<=0, go to ISSUE.
  - Otherwise go to IDLE.
- Pending request: st=1 sampled in ISSUE, WAIT or DONE sets pend (1-deep; extra requests are merged). st in DONE is honoured as pending in that same cycle.
- cv_done is ignored outside WAIT, including a stale level from the previous conversion seen during ISSUE.
- dec_* change only on their own store edge; unconverted channels keep their previous frame value.
- Reset values: state IDLE, ch 0, pend 0, all dec_* 16'h0000, cv_st 0, cv_bin 0, busy 0, frame_done 0, err_to 0, shadows 0.
- Reset asserted mid-frame aborts immediately; there is no partial-frame completion after release.

## Timing
- Converter latency: cv_done first high k cycles after the cv_st cycle, k≥1.
- Per channel: k+1 cycles.
- st sampled at edge E0 → frame_done high in cycle N_CH·(k+1)+1 after E0. For k=3: cycle 21.
- busy=1 from the cycle after E0 through the DONE cycle inclusive. busy=0 in the cycle after DONE unless pend restarts the frame.
- Back-to-back frames with pend: DONE is followed directly by ISSUE; one dead cycle per frame.
- Timeout channel costs TO_CYC+1 cycles.
- All outputs are registered except cv_st and busy, which are state decodes.

## Structure
- Shared package fsk_pkg holds: channel index constants CH_AMP..CH_AMIN, N_CH, DEC_ERR=16'hFFFF, and the state encoding.
- Single module; the timeout counter and shadow bank are inline. No sub-module.
- The converter stays external, instantiated once beside the scheduler in the receiver top level.

## Test plan
- Converter model with k=3; inputs 4095, 1234, 0, 7, 800; st pulse → cv_st pulses 4 cycles apart; dec_* = 4095, 1234, 0000, 0007, 0800 (hex BCD); frame_done in cycle 21; err_to=0.
- st re-pulsed mid-frame while inputs change to 1, 2, 3, 4, 5 → first frame completes with the old values; second frame starts immediately after DONE; final dec_* = 0001..0005; exactly two frame_done pulses.
- Converter never asserts cv_done for channel 2 → dec_af1=FFFF and err_to=1; the other channels are correct; the next clean frame clears err_to.
- cv_done held high continuously → no channel stored during ISSUE; each channel still takes 2 cycles; results correct.
- rst_n pulled low in WAIT of channel 3 → all outputs return to reset values asynchronously; no cv_st until the next st; the next frame completes normally.
- st held high for 50 cycles → frames repeat back-to-back; busy stays high except never low between frames; a frame_done pulse every N_CH·(k+1)+1 cycles.

Source files
------------

// File: rtl/fsk_dec_scheduler_pkg.sv
// Shared constants and state encoding for the FSK receiver display-conversion scheduler.
package fsk_pkg;
   localparam int N_CH   = 5;
   localparam int W_BIN  = 12;
   localparam int W_DEC  = 16;
   localparam int TO_CYC = 64;
   localparam int TO_W   = $clog2(TO_CYC);

   localparam int CH_AMP  = 0;
   localparam int CH_SH   = 1;
   localparam int CH_AF1  = 2;
   localparam int CH_AF2  = 3;
   localparam int CH_AMIN = 4;

   localparam logic [W_DEC-1:0] DEC_ERR = 16'hFFFF;

   typedef logic [2:0] ch_t;
   localparam ch_t CH_LAST = ch_t'(N_CH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/fsk_dec_scheduler_if.sv
// Start/done handshake between the scheduler and the shared binary-to-BCD converter.
interface fsk_cv_if
   import fsk_pkg::*;
   ;
   logic             cv_st;
   logic [W_BIN-1:0] cv_bin;
   logic [W_DEC-1:0] cv_dec;
   logic             cv_done;

   modport master (output cv_st, cv_bin, input  cv_dec, cv_done);
   modport slave  (input  cv_st, cv_bin, output cv_dec, cv_done);
endinterface

// File: rtl/fsk_dec_scheduler.sv
// Time-multiplexes one binary-to-BCD converter across the five receiver display values.
// state | meaning
// IDLE  | waiting for a refresh request
// ISSUE | converter start pulse for channel ch
// WAIT  | waiting for cv_done or timeout on channel ch
// DONE  | frame complete; restart at once if a request is pending
module fsk_dec_scheduler
   import fsk_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             st,
   input  logic [W_BIN-1:0] bin_amp,
   input  logic [W_BIN-1:0] bin_sh,
   input  logic [W_BIN-1:0] bin_af1,
   input  logic [W_BIN-1:0] bin_af2,
   input  logic [W_BIN-1:0] bin_amin,
   fsk_cv_if.master         cv,
   output logic [W_DEC-1:0] dec_amp,
   output logic [W_DEC-1:0] dec_sh,
   output logic [W_DEC-1:0] dec_af1,
   output logic [W_DEC-1:0] dec_af2,
   output logic [W_DEC-1:0] dec_amin,
   output logic             busy,
   output logic             frame_done,
   output logic             err_to
);

   state_t           state;
   ch_t              ch;
   logic             pend;
   logic [TO_W-1:0]  to_cnt;
   logic [W_BIN-1:0] cv_bin_q;
   logic [W_BIN-1:0] shadow [N_CH];
   logic [W_DEC-1:0] dec_q  [N_CH];
   logic [W_BIN-1:0] bin_in [N_CH];

   assign bin_in[CH_AMP]  = bin_amp;
   assign bin_in[CH_SH]   = bin_sh;
   assign bin_in[CH_AF1]  = bin_af1;
   assign bin_in[CH_AF2]  = bin_af2;
   assign bin_in[CH_AMIN] = bin_amin;

   assign cv.cv_st  = (state == S_ISSUE);
   assign cv.cv_bin = cv_bin_q;
   assign busy      = (state != S_IDLE);

   assign dec_amp  = dec_q[CH_AMP];
   assign dec_sh   = dec_q[CH_SH];
   assign dec_af1  = dec_q[CH_AF1];
   assign dec_af2  = dec_q[CH_AF2];
   assign dec_amin = dec_q[CH_AMIN];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ch         <= '0;
         pend       <= 1'b0;
         to_cnt     <= '0;
         cv_bin_q   <= '0;
         frame_done <= 1'b0;
         err_to     <= 1'b0;
         for (int i = 0; i < N_CH; i++) begin
            shadow[i] <= '0;
            dec_q[i]  <= '0;
         end
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (st) begin
                  for (int i = 0; i < N_CH; i++) shadow[i] <= bin_in[i];
                  cv_bin_q <= bin_in[CH_AMP];
                  ch       <= '0;
                  err_to   <= 1'b0;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (st) pend <= 1'b1;
               to_cnt <= TO_W'(TO_CYC - 1);
               state  <= S_WAIT;
            end
            S_WAIT: begin
               if (st) pend <= 1'b1;
               if (cv.cv_done || to_cnt == '0) begin
                  // a late cv_done on the timeout cycle still wins over the error code
                  if (cv.cv_done) begin
                     dec_q[ch] <= cv.cv_dec;
                  end else begin
                     dec_q[ch] <= DEC_ERR;
                     err_to    <= 1'b1;
                  end
                  if (ch == CH_LAST) begin
                     frame_done <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     ch       <= ch + ch_t'(1);
                     cv_bin_q <= shadow[ch + ch_t'(1)];
                     state    <= S_ISSUE;
                  end
               end else begin
                  to_cnt <= to_cnt - TO_W'(1);
               end
            end
            S_DONE: begin
               if (pend || st) begin
                  pend <= 1'b0;
                  for (int i = 0; i < N_CH; i++) shadow[i] <= bin_in[i];
                  cv_bin_q <= bin_in[CH_AMP];
                  ch       <= '0;
                  err_to   <= 1'b0;
                  state    <= S_ISSUE;
               end else begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fsk_dec_scheduler.sv
// Self-checking bench for fsk_dec_scheduler with a behavioural latency-k converter model.
module tb_fsk_dec_scheduler;
   import fsk_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic st = 1'b0;
   logic [11:0] bin_amp = '0, bin_sh = '0, bin_af1 = '0, bin_af2 = '0, bin_amin = '0;
   logic [15:0] dec_amp, dec_sh, dec_af1, dec_af2, dec_amin;
   logic busy, frame_done, err_to;

   fsk_cv_if cv ();

   always #5 clk = ~clk;

   fsk_dec_scheduler dut (
      .clk(clk), .rst_n(rst_n), .st(st),
      .bin_amp(bin_amp), .bin_sh(bin_sh), .bin_af1(bin_af1), .bin_af2(bin_af2), .bin_amin(bin_amin),
      .cv(cv.master),
      .dec_amp(dec_amp), .dec_sh(dec_sh), .dec_af1(dec_af1), .dec_af2(dec_af2), .dec_amin(dec_amin),
      .busy(busy), .frame_done(frame_done), .err_to(err_to)
   );

   function automatic logic [15:0] bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   // converter: cv_done high k cycles after the cv_st cycle; optional stuck-high or silent operand
   int          k_tb = 3;
   bit          hold_mode = 1'b0;
   bit          drop_en = 1'b0;
   logic [11:0] drop_val = '0;
   logic [11:0] op = '0;
   int          cnt = 0;

   always @(posedge clk) begin
      if (cv.cv_st) begin
         op  <= cv.cv_bin;
         cnt <= k_tb;
      end else if (cnt > 0) begin
         cnt <= cnt - 1;
      end
   end
   assign cv.cv_done = hold_mode | ((cnt == 1) && !(drop_en && op == drop_val));
   assign cv.cv_dec  = bcd(int'(op));

   int fd_cnt = 0;
   always @(negedge clk) if (frame_done) fd_cnt++;

   int checks = 0;
   int errors = 0;
   int vin [5];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] get_dec(input int i);
      case (i)
         0: return dec_amp;
         1: return dec_sh;
         2: return dec_af1;
         3: return dec_af2;
         default: return dec_amin;
      endcase
   endfunction

   task automatic apply_inputs();
      bin_amp  = 12'(vin[0]);
      bin_sh   = 12'(vin[1]);
      bin_af1  = 12'(vin[2]);
      bin_af2  = 12'(vin[3]);
      bin_amin = 12'(vin[4]);
   endtask

   task automatic check_results(input string tag, input int vals [5], input int drop_ch);
      for (int i = 0; i < 5; i++)
         chk($sformatf("%s_dec%0d", tag, i), 32'(get_dec(i)),
             32'((i == drop_ch) ? 16'hFFFF : bcd(vals[i])));
      chk({tag, "_err_to"}, 32'(err_to), 32'(drop_ch >= 0));
   endtask

   task automatic check_reset_state(input string tag);
      for (int i = 0; i < 5; i++) chk($sformatf("%s_dec%0d", tag, i), 32'(get_dec(i)), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_cv_st"}, 32'(cv.cv_st), 0);
      chk({tag, "_cv_bin"}, 32'(cv.cv_bin), 0);
      chk({tag, "_frame_done"}, 32'(frame_done), 0);
      chk({tag, "_err_to"}, 32'(err_to), 0);
   endtask

   // one frame from IDLE; expected cv_st positions and frame_done cycle from per-channel cost
   task automatic run_frame(input string tag, input int drop_ch);
      int n, idx, exp_pos, cost;
      cost = hold_mode ? 2 : k_tb + 1;
      @(negedge clk);
      apply_inputs();
      st = 1'b1;
      @(posedge clk); #1;
      st = 1'b0;
      n = 1; idx = 0; exp_pos = 1;
      while (!frame_done && n < 3000) begin
         if (cv.cv_st) begin
            chk($sformatf("%s_cvst_pos%0d", tag, idx), n, exp_pos);
            if (idx < 5) chk($sformatf("%s_cvbin%0d", tag, idx), 32'(cv.cv_bin), vin[idx]);
            exp_pos += (idx == drop_ch) ? TO_CYC + 1 : cost;
            idx++;
         end
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_done_cycle"}, n, exp_pos);
      chk({tag, "_nissue"}, idx, 5);
      chk({tag, "_busy_done"}, 32'(busy), 1);
      check_results(tag, vin, drop_ch);
      @(posedge clk); #1;
      chk({tag, "_busy_after"}, 32'(busy), 0);
      chk({tag, "_fd_after"}, 32'(frame_done), 0);
   endtask

   initial begin
      int n, old [5];
      bit saw_st;

      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // basic frame
      vin = '{4095, 1234, 0, 7, 800};
      run_frame("basic", -1);

      // request during a frame is queued and restarts right after DONE
      old = '{11, 22, 33, 44, 55};
      vin = old;
      fd_cnt = 0;
      @(negedge clk);
      apply_inputs();
      st = 1'b1;
      @(posedge clk); #1;
      st = 1'b0;
      n = 1;
      while (!frame_done && n < 3000) begin
         if (n == 8) begin
            vin = '{1, 2, 3, 4, 5};
            apply_inputs();
            st = 1'b1;
         end
         @(posedge clk); #1;
         st = 1'b0;
         n++;
      end
      chk("pend_first_done", n, 21);
      check_results("pend_first", old, -1);
      @(posedge clk); #1;
      n++;
      chk("pend_restart_cvst", 32'(cv.cv_st), 1);
      chk("pend_restart_busy", 32'(busy), 1);
      chk("pend_restart_cvbin", 32'(cv.cv_bin), 1);
      while (!frame_done && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("pend_second_done", n, 42);
      check_results("pend_second", vin, -1);
      repeat (5) @(posedge clk);
      #1;
      chk("pend_fd_count", fd_cnt, 2);
      chk("pend_idle_busy", 32'(busy), 0);

      // channel 2 never answers
      vin = '{100, 200, 333, 400, 500};
      drop_val = 12'd333;
      drop_en = 1'b1;
      run_frame("timeout", 2);
      chk("timeout_err_sticky", 32'(err_to), 1);
      drop_en = 1'b0;
      vin = '{9, 99, 999, 3210, 1};
      run_frame("after_to", -1);

      // converter done stuck high
      hold_mode = 1'b1;
      vin = '{321, 4000, 56, 1, 2048};
      run_frame("hold", -1);
      hold_mode = 1'b0;
      repeat (4) @(posedge clk);

      // reset in WAIT of channel 3
      vin = '{1111, 2222, 3333, 4044, 505};
      @(negedge clk);
      apply_inputs();
      st = 1'b1;
      @(posedge clk); #1;
      st = 1'b0;
      repeat (13) @(posedge clk);
      #1;
      chk("rst_in_wait_busy", 32'(busy), 1);
      chk("rst_in_wait_cvst", 32'(cv.cv_st), 0);
      rst_n = 1'b0;
      #1;
      check_reset_state("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      saw_st = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (cv.cv_st || busy) saw_st = 1'b1;
      end
      chk("rst_no_restart", 32'(saw_st), 0);
      vin = '{42, 4094, 10, 100, 1000};
      run_frame("post_rst", -1);

      // st held high for 50 edges
      vin = '{5, 50, 500, 3000, 4001};
      fd_cnt = 0;
      @(negedge clk);
      apply_inputs();
      st = 1'b1;
      @(posedge clk); #1;
      for (n = 1; n <= 90; n++) begin
         if (n == 50) st = 1'b0;
         chk($sformatf("held_busy_c%0d", n), 32'(busy), 32'(n <= 84));
         chk($sformatf("held_fd_c%0d", n), 32'(frame_done), 32'((n % 21 == 0) && (n <= 84)));
         @(posedge clk); #1;
      end
      chk("held_fd_count", fd_cnt, 4);
      check_results("held", vin, -1);

      // randomized frames against the arithmetic BCD model
      for (int r = 0; r < 8; r++) begin
         k_tb = int'($urandom_range(1, 5));
         for (int i = 0; i < 5; i++) vin[i] = int'($urandom_range(0, 4095));
         run_frame($sformatf("rand%0d", r), -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
